instr_mem_responder: RTL and testbench

INSTR_MEM_RESPONDER -- requirements
Module: instr_mem_responder

---
 rtl/imem_pkg.sv | 17 +
 rtl/imem_load_assembler.sv | 52 +++++
 rtl/instr_mem_responder.sv | 142 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 315 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction memory responder.
package imem_pkg;

    // Controller states: serve fetches, drain in-flight responses, accept loader bytes.
    typedef enum logic [1:0] {
        SERVE = 2'd0,
        DRAIN = 2'd1,
        LOAD  = 2'd2
    } imem_state_t;

    // RISC-V "addi x0, x0, 0" returned on every faulting fetch.
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    localparam int DEFAULT_DEPTH_WORDS = 256;
    localparam int DEFAULT_LATENCY     = 1;

endpackage

// File: rtl/imem_load_assembler.sv
// Packs a little-endian byte stream into 32-bit words and issues one memory
// write per completed word at an auto-incrementing word pointer.
module imem_load_assembler
    import imem_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              accept,
    input  logic [7:0]        load_byte,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data
);

    logic [1:0]        byte_cnt;
    logic [23:0]       low_bytes;
    logic [ADDR_W-1:0] ptr;

    // Hold the three low lanes until the fourth byte completes the word; clear drops any partial word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
            ptr       <= '0;
        end else if (clear) begin
            byte_cnt  <= 2'd0;
            low_bytes <= 24'd0;
            ptr       <= '0;
        end else if (accept) begin
            case (byte_cnt)
                2'd0:    low_bytes[7:0]   <= load_byte;
                2'd1:    low_bytes[15:8]  <= load_byte;
                2'd2:    low_bytes[23:16] <= load_byte;
                default: ;
            endcase
            byte_cnt <= byte_cnt + 2'd1;
            // Pointer width equals log2(depth), so it wraps to 0 naturally.
            if (byte_cnt == 2'd3) begin
                ptr <= ptr + 1'b1;
            end
        end
    end

    // The fourth byte goes straight to the write port, so the word lands on the same edge.
    assign wr_en   = accept && (byte_cnt == 2'd3);
    assign wr_addr = ptr;
    assign wr_data = {load_byte, low_bytes};

endmodule

// File: rtl/instr_mem_responder.sv
// Instruction memory with a fixed-latency fetch port and a byte-stream loader.
// Handshake: a fetch is accepted in any cycle where instr_req && instr_gnt; its
// response appears exactly LATENCY cycles later with instr_rvalid=1. A loader
// byte is taken in any cycle where load_valid && load_ready.
module instr_mem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEFAULT_DEPTH_WORDS,
    parameter int LATENCY     = DEFAULT_LATENCY
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_req,
    input  logic [31:0] Instr_Addr,
    output logic        instr_gnt,
    output logic        instr_rvalid,
    output logic [31:0] Instr_rdata,
    output logic        instr_err,
    input  logic        load_en,
    input  logic        load_valid,
    input  logic [7:0]  load_byte,
    output logic        load_ready,
    output logic        load_done,
    output imem_state_t state_dbg
);

    localparam int ADDR_W = $clog2(DEPTH_WORDS);

    imem_state_t state;
    imem_state_t state_next;

    logic [31:0]        mem [DEPTH_WORDS];
    logic [LATENCY-1:0] pipe_valid;
    logic               pipe_err  [LATENCY];
    logic [31:0]        pipe_data [LATENCY];

    logic [ADDR_W-1:0]  word_idx;
    logic               addr_bad;
    logic               asm_clear;
    logic               byte_accept;
    logic               wr_en;
    logic [ADDR_W-1:0]  wr_addr;
    logic [31:0]        wr_data;

    // Misaligned or beyond-the-array addresses fault instead of aliasing.
    assign word_idx = Instr_Addr[ADDR_W+1:2];
    assign addr_bad = (Instr_Addr[1:0] != 2'b00) || (Instr_Addr[31:ADDR_W+2] != '0);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= SERVE;
        end else begin
            state <= state_next;
        end
    end

    // Next state plus the grant, ready and done strobes.
    always_comb begin
        state_next = state;
        instr_gnt  = 1'b0;
        load_ready = 1'b0;
        load_done  = 1'b0;
        unique case (state)
            SERVE: begin
                instr_gnt = instr_req && !load_en;
                if (load_en) begin
                    state_next = DRAIN;
                end
            end
            DRAIN: begin
                if (!load_en) begin
                    state_next = SERVE;
                end else if (pipe_valid == '0) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                // The exit cycle refuses bytes so a late byte cannot sneak in.
                if (load_en) begin
                    load_ready = 1'b1;
                end else begin
                    load_done  = 1'b1;
                    state_next = SERVE;
                end
            end
            default: state_next = SERVE;
        endcase
    end

    // Response valid shift register; a granted fetch enters at stage 0.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= instr_gnt;
            for (int i = 1; i < LATENCY; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Data/error stages carry no reset: they are only observed when the matching valid is set.
    always_ff @(posedge clk) begin
        pipe_err[0]  <= addr_bad;
        pipe_data[0] <= addr_bad ? NOP_INSN : mem[word_idx];
        for (int i = 1; i < LATENCY; i++) begin
            pipe_err[i]  <= pipe_err[i-1];
            pipe_data[i] <= pipe_data[i-1];
        end
    end

    // Program storage; deliberately not reset so contents survive reset and reloads.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Assembler state is held cleared outside LOAD, so every LOAD entry starts at word 0, lane 0.
    assign asm_clear   = (state != LOAD);
    assign byte_accept = load_valid && load_ready;

    imem_load_assembler #(
        .ADDR_W(ADDR_W)
    ) u_load_asm (
        .clk       (clk),
        .reset     (reset),
        .clear     (asm_clear),
        .accept    (byte_accept),
        .load_byte (load_byte),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data)
    );

    assign instr_rvalid = pipe_valid[LATENCY-1];
    assign Instr_rdata  = instr_rvalid ? pipe_data[LATENCY-1] : 32'h0;
    assign instr_err    = instr_rvalid && pipe_err[LATENCY-1];
    assign state_dbg    = state;

endmodule

// File: tb/tb_instr_mem_responder.sv
// Bench for instr_mem_responder: three instances (LATENCY 1, 2, 3) share one
// stimulus stream; a per-instance expected queue tracks every granted fetch.
module tb_instr_mem_responder;
    import imem_pkg::*;

    localparam int N     = 3;
    localparam int DEPTH = 256;
    localparam int AW    = 8;
    localparam logic [31:0] EXP_NOP = 32'h0000_0013;

    typedef struct {
        int          due;
        logic        err;
        logic [31:0] data;
    } exp_t;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        instr_req;
    logic [31:0] instr_addr;
    logic        load_en;
    logic        load_valid;
    logic [7:0]  load_byte;

    logic [N-1:0] gnt_w;
    logic [N-1:0] rvalid_w;
    logic [N-1:0] err_w;
    logic [N-1:0] ready_w;
    logic [N-1:0] done_w;
    logic [31:0]  rdata_w [N];
    imem_state_t  dbg_w   [N];

    for (genvar g = 0; g < N; g++) begin : g_dut
        instr_mem_responder #(
            .DEPTH_WORDS(DEPTH),
            .LATENCY    (g + 1)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .instr_req    (instr_req),
            .Instr_Addr   (instr_addr),
            .instr_gnt    (gnt_w[g]),
            .instr_rvalid (rvalid_w[g]),
            .Instr_rdata  (rdata_w[g]),
            .instr_err    (err_w[g]),
            .load_en      (load_en),
            .load_valid   (load_valid),
            .load_byte    (load_byte),
            .load_ready   (ready_w[g]),
            .load_done    (done_w[g]),
            .state_dbg    (dbg_w[g])
        );
    end

    // ---------------- scoreboard ----------------
    int          n_cmp = 0;
    int          n_bad = 0;
    int          cycle = 0;
    logic [31:0] mem_model [DEPTH];
    exp_t        exp_q [N][$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic exp_t predict(input int due, input logic [31:0] a);
        exp_t e;
        e.due = due;
        if (a[1:0] != 2'b00 || a >= 32'(4 * DEPTH)) begin
            e.err  = 1'b1;
            e.data = EXP_NOP;
        end else begin
            e.err  = 1'b0;
            e.data = mem_model[a[AW+1:2]];
        end
        return e;
    endfunction

    // Runs once per cycle at the falling edge: pop/compare responses, push grants.
    task automatic sb();
        exp_t e;
        cycle++;
        for (int g = 0; g < N; g++) begin
            if (reset) begin
                exp_q[g].delete();
            end else begin
                if (rvalid_w[g]) begin
                    n_cmp++;
                    assert (exp_q[g].size() != 0) else begin
                        n_bad++;
                        $error("FAIL rsp_unexpected[%0d]: observed rvalid=1 expected rvalid=0 at cycle %0d", g, cycle);
                    end
                    if (exp_q[g].size() != 0) begin
                        e = exp_q[g].pop_front();
                        chk($sformatf("rsp_cycle[%0d]", g), 32'(cycle), 32'(e.due));
                        chk($sformatf("rsp_data[%0d]", g), rdata_w[g], e.data);
                        chk($sformatf("rsp_err[%0d]", g), 32'(err_w[g]), 32'(e.err));
                    end
                end else begin
                    chk($sformatf("idle_rdata[%0d]", g), rdata_w[g], 32'h0);
                    if (exp_q[g].size() != 0) begin
                        chk($sformatf("rsp_late[%0d]", g), 32'(exp_q[g][0].due > cycle), 32'd1);
                    end
                end
                if (gnt_w[g]) begin
                    exp_q[g].push_back(predict(cycle + g + 1, instr_addr));
                end
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic half();
        @(negedge clk);
        sb();
    endtask

    task automatic rest();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        half();
        rest();
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_gnt"},    32'(gnt_w),    32'h0);
        chk({tag, "_rvalid"}, 32'(rvalid_w), 32'h0);
        chk({tag, "_err"},    32'(err_w),    32'h0);
        chk({tag, "_ready"},  32'(ready_w),  32'h0);
        chk({tag, "_done"},   32'(done_w),   32'h0);
        for (int g = 0; g < N; g++) begin
            chk({tag, "_rdata"}, rdata_w[g], 32'h0);
            chk({tag, "_state"}, 32'(dbg_w[g]), 32'(SERVE));
        end
    endtask

    // Enter loader mode, stream n bytes, optionally leave with a stray byte on the exit cycle.
    task automatic load_seq(input logic [7:0] b [16], input int n, input logic do_exit, input logic junk);
        int waited;
        waited  = 0;
        load_en = 1'b1;
        #1;
        while (!(&ready_w) && waited < 20) begin
            tick();
            waited++;
        end
        chk("load_ready_rise", 32'(ready_w), 32'h7);
        for (int i = 0; i < n; i++) begin
            load_valid = 1'b1;
            load_byte  = b[i];
            tick();
        end
        load_valid = 1'b0;
        if (do_exit) begin
            load_en = 1'b0;
            if (junk) begin
                load_valid = 1'b1;
                load_byte  = 8'hEE;
            end
            half();
            chk("load_done_pulse", 32'(done_w), 32'h7);
            rest();
            load_valid = 1'b0;
            half();
            chk("load_done_clear", 32'(done_w), 32'h0);
            rest();
        end
    endtask

    task automatic fetch_seq(input logic [31:0] a [4], input int n);
        for (int i = 0; i < n; i++) begin
            instr_req  = 1'b1;
            instr_addr = a[i];
            half();
            chk("fetch_gnt", 32'(gnt_w), 32'h7);
            rest();
        end
        instr_req = 1'b0;
        repeat (6) tick();
        for (int g = 0; g < N; g++) begin
            chk($sformatf("drained[%0d]", g), 32'(exp_q[g].size()), 32'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200000 ns");
        $fatal(1, "watchdog");
    end

    // ---------------- directed sequence ----------------
    initial begin
        logic [7:0]  b [16];
        logic [31:0] a [4];
        logic [N-1:0] seen;

        reset = 1'b1; instr_req = 1'b0; instr_addr = 32'h0;
        load_en = 1'b0; load_valid = 1'b0; load_byte = 8'h0;
        repeat (2) tick();
        half();
        check_all_zero("reset");
        rest();
        reset = 1'b0;
        tick();

        // Two-word program, then fetch it back.
        b = '{8'h13, 8'h05, 8'hA0, 8'h00, 8'h93, 8'h05, 8'hB0, 8'h00,
              8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00};
        load_seq(b, 8, 1'b1, 1'b0);
        mem_model[0] = 32'h00A0_0513;
        mem_model[1] = 32'h00B0_0593;
        a = '{32'h0, 32'h4, 32'h0, 32'h0};
        fetch_seq(a, 2);

        // Misaligned and out-of-range fetches.
        a = '{32'h2, 32'h400, 32'h3, 32'hFFFF_FFFC};
        fetch_seq(a, 4);

        // Four random words, then four back-to-back fetches.
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
        load_seq(b, 16, 1'b1, 1'b0);
        for (int w = 0; w < 4; w++) mem_model[w] = {b[4*w+3], b[4*w+2], b[4*w+1], b[4*w]};
        a = '{32'h0, 32'h4, 32'h8, 32'hC};
        fetch_seq(a, 4);

        // Reset with a fetch in flight drops the response.
        instr_req  = 1'b1;
        instr_addr = 32'h4;
        half();
        chk("rstfetch_gnt", 32'(gnt_w), 32'h7);
        #1;
        reset     = 1'b1;
        instr_req = 1'b0;
        #1;
        chk("rstfetch_rvalid", 32'(rvalid_w), 32'h0);
        rest();
        tick();
        reset = 1'b0;
        repeat (5) tick();

        // Loader request with two fetches in flight.
        instr_req  = 1'b1;
        instr_addr = 32'h0;
        half(); chk("drain_gnt0", 32'(gnt_w), 32'h7); rest();
        instr_addr = 32'h4;
        half(); chk("drain_gnt1", 32'(gnt_w), 32'h7); rest();
        instr_addr = 32'h8;
        load_en    = 1'b1;
        half(); chk("drain_gnt_blocked", 32'(gnt_w), 32'h0); rest();
        instr_req = 1'b0;
        half();
        for (int g = 0; g < N; g++) chk($sformatf("drain_state[%0d]", g), 32'(dbg_w[g]), 32'(DRAIN));
        chk("drain_ready_low", 32'(ready_w), 32'h0);
        rest();
        seen = '0;
        for (int k = 0; k < 12 && seen != 3'b111; k++) begin
            half();
            for (int g = 0; g < N; g++) begin
                if (rvalid_w[g]) chk($sformatf("ready_in_drain[%0d]", g), 32'(ready_w[g]), 32'h0);
                if (ready_w[g] && !seen[g]) begin
                    seen[g] = 1'b1;
                    chk($sformatf("drained_before_ready[%0d]", g), 32'(exp_q[g].size()), 32'h0);
                end
            end
            rest();
        end
        chk("drain_ready_rose", 32'(seen), 32'h7);

        // Six bytes: word 0 replaced, partial word 1 discarded.
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
        load_seq(b, 6, 1'b1, 1'b0);
        mem_model[0] = {b[3], b[2], b[1], b[0]};
        a = '{32'h0, 32'h4, 32'h8, 32'h0};
        fetch_seq(a, 3);

        // Seven bytes plus a byte offered on the exit cycle: word 1 must stay intact.
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
        load_seq(b, 7, 1'b1, 1'b1);
        mem_model[0] = {b[3], b[2], b[1], b[0]};
        a = '{32'h0, 32'h4, 32'h0, 32'h0};
        fetch_seq(a, 2);

        // Reset in the middle of a load after two bytes.
        for (int i = 0; i < 16; i++) b[i] = 8'($urandom_range(0, 255));
        load_seq(b, 2, 1'b0, 1'b0);
        #1;
        reset = 1'b1;
        #1;
        check_all_zero("rstload");
        load_en = 1'b0;
        tick();
        reset = 1'b0;
        for (int k = 0; k < 3; k++) begin
            half();
            chk("rstload_no_done", 32'(done_w), 32'h0);
            rest();
        end
        a = '{32'h0, 32'h4, 32'h0, 32'h0};
        fetch_seq(a, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
